// File: rtl/note_pkg.sv
// Shared constants, note index enumeration and helpers for the note detector.
package note_pkg;

    localparam int unsigned PERIOD_W  = 17;
    localparam int unsigned CLK_HZ    = 25_000_000;
    localparam int unsigned NUM_NOTES = 8;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    // Index order follows the switch/speaker order of the note outputs.
    typedef enum logic [2:0] {
        NoteC4,
        NoteD4,
        NoteE4,
        NoteF4,
        NoteG4,
        NoteA4,
        NoteB4,
        NoteC5
    } note_idx_e;

    // Nominal full periods in clk cycles at CLK_HZ.
    localparam logic [PERIOD_W-1:0] NOM_PERIOD [0:NUM_NOTES-1] = '{
        17'd95556, 17'd85132, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50620, 17'd47778
    };

    function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                     input logic [PERIOD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [NUM_NOTES-1:0] note_onehot(input note_idx_e idx);
        logic [NUM_NOTES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// Multi-flop synchronizer for the asynchronous tone input plus a rising-edge strobe.
module tone_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tone_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the input through the synchronizer chain; remember the last synced level.
    always_comb begin
        sync_d[0] = tone_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-detect state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square-wave tone and reports the matching note once it is stable.
module note_detector
    import note_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = 3,
    parameter int unsigned TOL_SHIFT   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tone_in,
    output logic [NUM_NOTES-1:0] note,
    output logic                 note_valid,
    output logic                 note_change,
    output logic [PERIOD_W-1:0]  period
);

    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [NUM_NOTES-1:0]  note_q, note_d;
    logic                  change_q, change_d;
    note_idx_e             cand_q, cand_d;
    logic [CNT_W-1:0]      stab_q, stab_d;

    logic                  edge_stb;
    logic [PERIOD_W-1:0]   meas_p;
    logic                  match_hit;
    note_idx_e             match_idx;
    logic [CNT_W-1:0]      stab_next;
    logic [NUM_NOTES-1:0]  match_oh;

    tone_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .tone_i(tone_in),
        .rise_o(edge_stb)
    );

    // Counter holds (period - 1) when the closing edge arrives.
    assign meas_p = cnt_q + PERIOD_W'(1);

    // Classify the candidate period against every note window; windows never overlap.
    always_comb begin
        match_hit = 1'b0;
        match_idx = NoteC4;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (abs_diff(meas_p, NOM_PERIOD[i]) <= (NOM_PERIOD[i] >> TOL_SHIFT)) begin
                match_hit = 1'b1;
                match_idx = note_idx_e'(3'(i));
            end
        end
        match_oh = note_onehot(match_idx);
    end

    // Next-state: period measurement FSM, stability counting and note reporting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        note_d    = note_q;
        change_d  = 1'b0;
        cand_d    = cand_q;
        stab_d    = stab_q;
        stab_next = stab_q;

        unique case (state_q)
            StIdle: begin
                if (edge_stb) begin
                    state_d = StMeasure;
                    cnt_d   = '0;
                end
            end
            StMeasure: begin
                if (cnt_q == PERIOD_MAX) begin
                    // Tone lost: drop the note; a coincident edge restarts measurement.
                    note_d   = '0;
                    stab_d   = '0;
                    change_d = note_valid;
                    cnt_d    = '0;
                    state_d  = edge_stb ? StMeasure : StIdle;
                end else if (edge_stb) begin
                    period_d = meas_p;
                    cnt_d    = '0;
                    if (match_hit) begin
                        if (match_idx == cand_q) begin
                            stab_next = (stab_q == CNT_W'(STABLE_CNT)) ? stab_q
                                                                       : stab_q + CNT_W'(1);
                        end else begin
                            cand_d    = match_idx;
                            stab_next = CNT_W'(1);
                        end
                        stab_d = stab_next;
                        if (stab_next == CNT_W'(STABLE_CNT) && (!note_valid || note_q != match_oh))
                        begin
                            note_d   = match_oh;
                            change_d = 1'b1;
                        end
                    end else begin
                        stab_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            note_q   <= '0;
            change_q <= 1'b0;
            cand_q   <= NoteC4;
            stab_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            note_q   <= note_d;
            change_q <= change_d;
            cand_q   <= cand_d;
            stab_q   <= stab_d;
        end
    end

    assign note        = note_q;
    assign note_valid  = |note_q;
    assign note_change = change_q;
    assign period      = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector: directed scenarios plus randomized jittered tones.
module tb_note_detector;

    localparam int G4 = 63776;
    localparam int E4 = 75843;

    int NOM [8] = '{95556, 85132, 75843, 71586, 63776, 56818, 50620, 47778};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tone_in = 1'b0;
    logic [7:0]  note;
    logic        note_valid;
    logic        note_change;
    logic [16:0] period;

    always #20 clk = ~clk;

    note_detector #(
        .SYNC_STAGES(2),
        .STABLE_CNT (3),
        .TOL_SHIFT  (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tone_in    (tone_in),
        .note       (note),
        .note_valid (note_valid),
        .note_change(note_change),
        .period     (period)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     chg_seen = 0;
    int     bad_cycles = 0;

    // Reference model state: last three classified periods decide the reported note.
    bit     armed;
    longint last_rise;
    int     hist[$];
    int     exp_idx;
    int     exp_period;
    int     chg_exp;
    int     chg_base;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (note_change) chg_seen <= chg_seen + 1;
    end

    always @(negedge clk) begin
        if (rst_n && (note_valid !== (|note) || $countones(note) > 1)) bad_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input int p);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = p - NOM[i];
            if (d < 0) d = -d;
            if (d <= NOM[i] / 64) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_note();
        logic [7:0] v;
        v = 8'h00;
        if (exp_idx >= 0) v[exp_idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        armed      = 1'b0;
        hist.delete();
        exp_idx    = -1;
        exp_period = 0;
        chg_exp    = 0;
    endtask

    task automatic model_timeout();
        if (exp_idx >= 0) chg_exp++;
        exp_idx = -1;
        armed   = 1'b0;
        hist.delete();
    endtask

    task automatic model_rise();
        longint gap;
        int     c;
        gap = cyc - last_rise;
        if (armed && gap >= 131072) model_timeout();
        if (!armed) begin
            armed = 1'b1;
        end else begin
            exp_period = int'(gap);
            c = classify(int'(gap));
            hist.push_back(c);
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3 && c >= 0 && hist[0] == c && hist[1] == c && c != exp_idx) begin
                exp_idx = c;
                chg_exp++;
            end
        end
        last_rise = cyc;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_note"}, 32'(note), 32'(exp_note()));
        check_eq({tag, "_valid"}, 32'(note_valid), 32'(exp_idx >= 0));
        check_eq({tag, "_period"}, 32'(period), 32'(exp_period));
    endtask

    // One full tone cycle of p clk cycles starting with a rising edge; called at a negedge.
    task automatic tone_cycle(input int p, input string tag);
        tone_in = 1'b1;
        model_rise();
        repeat (6) @(negedge clk);
        check_outputs(tag);
        repeat (p / 2 - 6) @(negedge clk);
        tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #7 rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_note"}, 32'(note), 32'h0);
        check_eq({tag, "_rst_valid"}, 32'(note_valid), 32'h0);
        check_eq({tag, "_rst_change"}, 32'(note_change), 32'h0);
        check_eq({tag, "_rst_period"}, 32'(period), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        if (tone_in) begin
            armed     = 1'b1;
            last_rise = cyc;
        end
        chg_base = chg_seen;
    endtask

    task automatic check_changes(input string tag);
        repeat (2) @(negedge clk);
        check_eq({tag, "_changes"}, 32'(chg_seen - chg_base), 32'(chg_exp));
    endtask

    initial begin
        model_reset();
        last_rise = 0;
        chg_base  = 0;
        repeat (2) @(negedge clk);

        // C4 from reset: reported at the 4th rising edge.
        do_reset("c4");
        for (int i = 0; i < 4; i++) tone_cycle(95556, "c4");
        check_eq("c4_final", 32'(note), 32'h01);
        check_changes("c4");
        check_eq("c4_pulses", 32'(chg_seen - chg_base), 32'd1);

        // A4 then C5.
        do_reset("a4c5");
        for (int i = 0; i < 4; i++) tone_cycle(56818, "a4");
        check_eq("a4_final", 32'(note), 32'h20);
        for (int i = 0; i < 4; i++) tone_cycle(47778, "c5");
        check_eq("c5_final", 32'(note), 32'h80);
        check_changes("a4c5");
        check_eq("a4c5_pulses", 32'(chg_seen - chg_base), 32'd2);

        // Alternating in/out of the B4 window never confirms.
        do_reset("b4alt");
        for (int i = 0; i < 6; i++) tone_cycle((i % 2 == 0) ? 51320 : 51520, "b4alt");
        tone_cycle(51320, "b4alt_end");
        check_eq("b4alt_final", 32'(note_valid), 32'h0);
        check_changes("b4alt");

        // E4 then tone lost: timeout after the counter saturates.
        do_reset("e4to");
        for (int i = 0; i < 4; i++) tone_cycle(E4, "e4");
        check_eq("e4_final", 32'(note), 32'h04);
        while (cyc - last_rise < 131060) @(negedge clk);
        check_eq("e4_before_to", 32'(note_valid), 32'h1);
        while (cyc - last_rise < 131090) @(negedge clk);
        model_timeout();
        check_eq("e4_after_to_note", 32'(note), 32'h0);
        check_eq("e4_after_to_valid", 32'(note_valid), 32'h0);
        tone_cycle(E4, "e4_rearm");
        check_changes("e4to");
        check_eq("e4to_pulses", 32'(chg_seen - chg_base), 32'd2);

        // Reset in the middle of a G4 measurement with tone high at release.
        do_reset("g4");
        for (int i = 0; i < 4; i++) tone_cycle(G4, "g4");
        tone_in = 1'b1;
        model_rise();
        repeat (1000) @(negedge clk);
        check_eq("g4_pre_rst", 32'(note), 32'h10);
        do_reset("g4mid");
        repeat (30000) @(negedge clk);
        tone_in = 1'b0;
        repeat (31888) @(negedge clk);
        for (int i = 0; i < 4; i++) tone_cycle(G4, "g4post");
        check_eq("g4post_final", 32'(note), 32'h10);
        check_changes("g4post");
        check_eq("g4post_pulses", 32'(chg_seen - chg_base), 32'd1);

        // Randomized notes with up to +/-1% jitter per period.
        do_reset("rnd");
        for (int s = 0; s < 4; s++) begin
            int n;
            n = int'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++) begin
                int j, p;
                j = NOM[n] / 100;
                p = NOM[n] + int'($urandom_range(0, 2 * j)) - j;
                tone_cycle(p, "rnd");
            end
        end
        check_changes("rnd");

        check_eq("onehot_bad_cycles", 32'(bad_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth on tone_in.
REQ-002 Parameter: STABLE_CNT, 3, consecutive matching periods before a note is reported.
REQ-003 Parameter: TOL_SHIFT, 6, match tolerance is nominal period >> TOL_SHIFT (~1.56%).
REQ-004 Port: clk  in  1  system clock, 25 MHz; sole clock.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: tone_in  in  1  asynchronous square-wave audio input, same waveform as the speaker tone generators.
REQ-007 Port: note  out  8  one-hot detected note; bit0=C4, bit1=D4, bit2=E4, bit3=F4, bit4=G4, bit5=A4, bit6=B4, bit7=C5 (switch/speaker order).
REQ-008 Port: note_valid  out  1  high while a note is reported.
REQ-009 Port: note_change  out  1  one-cycle pulse whenever note or note_valid changes.
REQ-010 Port: period  out  17  last measured full period, in clk cycles.

Function
REQ-011 tone_in SHALL pass through SYNC_STAGES flops, then a rising-edge detector; edge = one-cycle strobe.
REQ-012 FSM SHALL have states IDLE (no reference edge) and MEASURE; IDLE->MEASURE on edge, clearing the period counter.
REQ-013 In MEASURE, counter SHALL increment each cycle, saturating at 17'h1FFFF; on edge, measured period = counter+1, latched into period, counter cleared, state stays MEASURE.
REQ-014 Nominal periods (25 MHz): C4 95556, D4 85132, E4 75843, F4 71586, G4 63776, A4 56818, B4 50620, C5 47778.
REQ-015 Period p SHALL match note i iff |p - NOM[i]| <= NOM[i] >> TOL_SHIFT; windows are non-overlapping, so at most one match.
REQ-016 Stability: on match equal to candidate, count increments (saturating at STABLE_CNT); on a different match, candidate = match and count = 1; on no match, count = 0 and outputs hold.
REQ-017 When count reaches STABLE_CNT and (note_valid=0 or candidate != current note), note SHALL update to the candidate, note_valid=1, note_change=1 for one cycle.
REQ-018 Output update SHALL be registered the cycle after the edge strobe; total latency from tone_in rise to output <= SYNC_STAGES+2 cycles.
REQ-019 Timeout: counter reaching 17'h1FFFF without an edge SHALL force note=0, note_valid=0, count=0, state IDLE; note_change pulses only if note_valid was 1.
REQ-020 An edge in the saturation cycle SHALL take the timeout and also act as an IDLE start edge (counter cleared, MEASURE); no period latched.
REQ-021 Same note repeatedly confirmed SHALL NOT re-pulse note_change.
REQ-022 note SHALL always be all-zero or one-hot; note_valid equals |note.

Reset
REQ-023 rst_n low SHALL asynchronously clear note, note_valid, note_change, period, counters, candidate, synchronizer flops; state IDLE.
REQ-024 tone_in high at reset release SHALL yield at most an IDLE start edge, never a report.

Structure
REQ-025 Shared package note_pkg SHALL hold PERIOD_W=17, CLK_HZ=25_000_000, NOM_PERIOD[0:7] table, note index enumeration C4..C5.
REQ-026 Sub-module tone_sync_edge SHALL implement synchronizer plus rising-edge strobe; classifier and FSM stay in note_detector.

Verification
REQ-027 C4 square wave (95556-cycle period) after reset -> note=8'h01, note_valid=1, one note_change pulse after 4th rising edge (3 periods).
REQ-028 A4 at 56818 then switch to C5 at 47778 -> note 8'h20, then 8'h80 after 3 C5 periods; exactly two note_change pulses.
REQ-029 Period 50620+700 (outside B4 +/-790? no: inside) and 50620+900 (outside) alternating -> match resets count each miss; note never asserted.
REQ-030 E4 established then tone_in held low -> 131071 cycles after last edge note=0, note_valid=0, one note_change pulse; next edge only re-arms.
REQ-031 rst_n asserted mid-G4 measurement -> all outputs 0 immediately (asynchronous); after release 3 more G4 periods needed (4 edges) to report 8'h10.
REQ-032 Random glitch-free periods across all 8 notes with +/-1% jitter -> note always one-hot or zero, matches generating note after STABLE_CNT periods.
